// File: rtl/robot_odometry.sv
// ---------------------------------------------------------------------------
// robot_odometry
//
// Executes front/rotate movement commands from the wall-following controller.
// One command is accepted at a time. Each command drives timed turn and/or
// forward motor pulses, then commits the resulting heading, grid position
// and completed-move count.
//
// Parameters:
//   MOVE_CYCLES - cycles motor_fwd stays high per grid step (>= 1)
//   TURN_CYCLES - cycles motor_turn stays high per 90 deg CW turn (>= 1)
//   COORD_W     - width of each two's-complement position coordinate
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - synchronous, active-high reset
//   cmd_valid   - a command is present on front/rotate
//   front       - move one cell along the current heading
//   rotate      - rotate 90 deg clockwise (done before any move)
//   cmd_ready   - block is idle and accepts a command this cycle
//   motor_fwd   - forward motor enable
//   motor_turn  - turn motor enable
//   heading     - 0=N, 1=E, 2=S, 3=W
//   pos_x       - X coordinate, east positive
//   pos_y       - Y coordinate, north positive
//   step_count  - completed forward moves, saturating at 16'hFFFF
//   at_origin   - pos_x == 0 and pos_y == 0
// ---------------------------------------------------------------------------
module robot_odometry #(
    parameter int MOVE_CYCLES = 4,
    parameter int TURN_CYCLES = 2,
    parameter int COORD_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic               front,
    input  logic               rotate,
    output logic               cmd_ready,
    output logic               motor_fwd,
    output logic               motor_turn,
    output logic [1:0]         heading,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [15:0]        step_count,
    output logic               at_origin
);

    localparam int MAX_CYC = (MOVE_CYCLES > TURN_CYCLES) ? MOVE_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter counts down to zero; a state lasting N cycles loads N-1.
    localparam logic [CNT_W-1:0]   MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        MOVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 front_q, front_d;
    logic [1:0]           heading_q, heading_d;
    logic [COORD_W-1:0]   pos_x_q, pos_x_d;
    logic [COORD_W-1:0]   pos_y_q, pos_y_d;
    logic [15:0]          step_q, step_d;
    logic                 accept;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            front_q   <= 1'b0;
            heading_q <= 2'd0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            front_q   <= front_d;
            heading_q <= heading_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        front_d    = front_q;
        heading_d  = heading_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        step_d     = step_q;
        motor_fwd  = 1'b0;
        motor_turn = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only front needs to be remembered: rotate is fully resolved
                // by the IDLE->TURN decision. Both-zero is a silent no-op.
                if (accept) begin
                    front_d = front;
                    if (rotate) begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end else if (front) begin
                        state_d = MOVE;
                        cnt_d   = MOVE_LOAD;
                    end
                end
            end

            TURN: begin
                motor_turn = 1'b1;
                if (cnt_q == '0) begin
                    heading_d = heading_q + 2'd1;
                    if (front_q) begin
                        state_d = MOVE;
                        cnt_d   = MOVE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            MOVE: begin
                motor_fwd = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    unique case (heading_q)
                        2'd0: pos_y_d = pos_y_q + COORD_ONE;
                        2'd1: pos_x_d = pos_x_q + COORD_ONE;
                        2'd2: pos_y_d = pos_y_q - COORD_ONE;
                        2'd3: pos_x_d = pos_x_q - COORD_ONE;
                        default: ;
                    endcase
                    if (step_q != '1) begin
                        step_d = step_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign heading    = heading_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign step_count = step_q;
    assign at_origin  = (pos_x_q == '0) && (pos_y_q == '0);

endmodule

// File: tb/tb_robot_odometry.sv
// ---------------------------------------------------------------------------
// tb_robot_odometry
//
// Scoreboard bench for robot_odometry. The stimulus side runs a reference
// model of each command (turn count, move count, resulting heading/position/
// steps) and queues the expected outcome; the monitor detects accepts on the
// DUT interface, measures the motor pulse train and compares the final state.
// ---------------------------------------------------------------------------
module tb_robot_odometry;

    localparam int MC = 4;
    localparam int TC = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          front = 1'b0;
    logic          rotate = 1'b0;
    logic          cmd_ready, motor_fwd, motor_turn, at_origin;
    logic [1:0]    heading;
    logic [CW-1:0] pos_x, pos_y;
    logic [15:0]   step_count;

    robot_odometry #(
        .MOVE_CYCLES(MC),
        .TURN_CYCLES(TC),
        .COORD_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .front     (front),
        .rotate    (rotate),
        .cmd_ready (cmd_ready),
        .motor_fwd (motor_fwd),
        .motor_turn(motor_turn),
        .heading   (heading),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .step_count(step_count),
        .at_origin (at_origin)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            t;
        int            f;
        logic [1:0]    h;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [15:0]   s;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [1:0]    m_h;
    logic [CW-1:0] m_x, m_y;
    logic [15:0]   m_s;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 2'd0; m_x = '0; m_y = '0; m_s = 16'd0;
    endtask

    // Command semantics: rotate (if requested) then move along the new heading.
    task automatic model_cmd(input logic f, input logic r);
        exp_t e;
        e.t = 0;
        e.f = 0;
        if (r) begin
            e.t = TC;
            m_h = m_h + 2'd1;
        end
        if (f) begin
            e.f = MC;
            case (m_h)
                2'd0: m_y = m_y + 1'b1;
                2'd1: m_x = m_x + 1'b1;
                2'd2: m_y = m_y - 1'b1;
                default: m_x = m_x - 1'b1;
            endcase
            if (m_s != 16'hFFFF) m_s = m_s + 16'd1;
        end
        e.h = m_h; e.x = m_x; e.y = m_y; e.s = m_s;
        exp_q.push_back(e);
    endtask

    // Issue a command (block must be idle), return once ready again.
    // Inputs are left as-is so a following send() is back-to-back.
    task automatic send(input logic f, input logic r, input bit toggle);
        int n;
        model_cmd(f, r);
        cmd_valid = 1'b1; front = f; rotate = r;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        while (!cmd_ready && n < 100) begin
            if (toggle) begin
                cmd_valid = 1'($urandom);
                front     = 1'($urandom);
                rotate    = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0; front = 1'b0; rotate = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; front = 1'b0; rotate = 1'b0;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: called at the negedge where an accept is visible; returns at
    // the negedge where cmd_ready is high again (or on reset abort).
    task automatic mon_txn();
        exp_t e;
        int tn, fn, n;
        bit order_ok, seen_f;
        if (exp_q.size() == 0) begin
            chk("unexpected_accept", 32'd1, 32'd0);
            @(negedge clk);
            return;
        end
        e = exp_q.pop_front();
        tn = 0; fn = 0; n = 0; order_ok = 1'b1; seen_f = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) return;
            if (cmd_ready) break;
            if (motor_turn && motor_fwd) order_ok = 1'b0;
            if (!motor_turn && !motor_fwd) order_ok = 1'b0;
            if (motor_turn) begin
                if (seen_f) order_ok = 1'b0;
                tn++;
            end
            if (motor_fwd) begin
                seen_f = 1'b1;
                fn++;
            end
            n++;
            if (n > 100) begin
                chk("busy_timeout", 32'd1, 32'd0);
                return;
            end
        end
        chk("turn_cycles", tn, e.t);
        chk("fwd_cycles", fn, e.f);
        chk("pulse_order", {31'd0, order_ok}, 32'd1);
        chk("heading", {30'd0, heading}, {30'd0, e.h});
        chk("pos_x", {24'd0, pos_x}, {24'd0, e.x});
        chk("pos_y", {24'd0, pos_y}, {24'd0, e.y});
        chk("step_count", {16'd0, step_count}, {16'd0, e.s});
        chk("at_origin", {31'd0, at_origin}, {31'd0, (e.x == '0) && (e.y == '0)});
    endtask

    task automatic stimulus();
        int unsigned c0;
        exp_t dummy;

        // reset state
        do_reset();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_motors", {30'd0, motor_fwd, motor_turn}, 32'd0);
        chk("rst_heading", {30'd0, heading}, 32'd0);
        chk("rst_pos", {16'd0, pos_x, pos_y}, 32'd0);
        chk("rst_steps", {16'd0, step_count}, 32'd0);
        chk("rst_origin", {31'd0, at_origin}, 32'd1);

        // single forward move
        send(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        chk("fwd1_pos_y", {24'd0, pos_y}, 32'd1);

        // four back-to-back rotates with cmd_valid held high
        c0 = cyc;
        repeat (4) send(1'b0, 1'b1, 1'b0);
        chk("rot4_cycles", cyc - c0, 4 * (TC + 1));
        idle_cycles(2);

        // compound from N
        do_reset();
        send(1'b1, 1'b1, 1'b0);
        idle_cycles(2);
        chk("cmpd_pos_x", {24'd0, pos_x}, 32'd1);

        // fwd, rot, rot, fwd back-to-back with inputs toggling while busy
        do_reset();
        c0 = cyc;
        send(1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        chk("seq_cycles", cyc - c0, 2 * (MC + 1) + 2 * (TC + 1));
        idle_cycles(2);
        chk("seq_origin", {31'd0, at_origin}, 32'd1);

        // no-op accept
        send(1'b0, 1'b0, 1'b0);
        chk("noop_ready", {31'd0, cmd_ready}, 32'd1);
        idle_cycles(2);

        // coordinate wrap: 128 steps north
        do_reset();
        repeat (128) send(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        chk("wrap_pos_y", {24'd0, pos_y}, 32'h80);

        // reset in the 2nd forward cycle aborts the move
        dummy = '{t: 0, f: 0, h: 2'd0, x: '0, y: '0, s: 16'd0};
        exp_q.push_back(dummy);
        cmd_valid = 1'b1; front = 1'b1; rotate = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; front = 1'b0;
        @(posedge clk); #1;
        chk("abort_fwd_on", {31'd0, motor_fwd}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("abort_motors", {30'd0, motor_fwd, motor_turn}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_pos", {16'd0, pos_x, pos_y}, 32'd0);
        chk("abort_steps", {16'd0, step_count}, 32'd0);
        idle_cycles(2);

        // randomized commands
        for (int i = 0; i < 80; i++) begin
            send(1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(4);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        model_reset();
        fork
            stimulus();
            begin
                forever begin
                    @(negedge clk);
                    while (!reset && cmd_valid && cmd_ready) mon_txn();
                end
            end
            begin
                #2_000_000;
                chk("global_timeout", 32'd1, 32'd0);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/robot_odometry.md
# robot_odometry

Executes movement commands from the wall-following controller. It accepts one `front`/`rotate` command at a time and drives timed forward and turn motor pulses. It also keeps track of the robot's heading, its grid position and the number of completed moves. The block sits directly downstream of the controller's `front`/`rotate` outputs, and `cmd_ready` paces the controller.

## Interface
Parameters:
- `MOVE_CYCLES`, default 4: number of cycles `motor_fwd` stays high for one grid step. Legal range is 1 or more.
- `TURN_CYCLES`, default 2: number of cycles `motor_turn` stays high for one 90° clockwise turn. Legal range is 1 or more.
- `COORD_W`, default 8: width of each position coordinate, in two's complement.

Ports:
- `clk` in 1: the block's single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is present on `front`/`rotate`.
- `front` in 1: move one grid cell along the current heading.
- `rotate` in 1: rotate 90° clockwise.
- `cmd_ready` out 1: the block can accept a command this cycle.
- `motor_fwd` out 1: forward motor enable.
- `motor_turn` out 1: turn motor enable.
- `heading` out 2: current heading. 0=N, 1=E, 2=S, 3=W.
- `pos_x` out COORD_W: X coordinate. East is positive.
- `pos_y` out COORD_W: Y coordinate. North is positive.
- `step_count` out 16: number of completed forward moves.
- `at_origin` out 1: high when `pos_x`==0 and `pos_y`==0.

## Operation
- FSM states: IDLE, TURN, MOVE.
- `cmd_ready` = (state==IDLE). This is a combinational decode of the registered state.
- Accept condition: `cmd_valid` & `cmd_ready`. On accept, latch `front` and `rotate`.
- When not in IDLE, `front`, `rotate` and `cmd_valid` are ignored.
- Transitions from IDLE on accept:
  - `rotate`=1 → TURN. This holds whatever the value of `front`.
  - `rotate`=0, `front`=1 → MOVE.
  - both 0 → stay in IDLE as a no-op. No counter or output changes.
- TURN:
  - `motor_turn`=1 for exactly TURN_CYCLES cycles.
  - On the edge that ends the last turn cycle: `heading` ← `heading`+1 mod 4 (W wraps to N).
  - Next state is MOVE if the latched `front` is 1, otherwise IDLE.
- MOVE:
  - `motor_fwd`=1 for exactly MOVE_CYCLES cycles.
  - On the edge that ends the last move cycle, update the position by `heading`:
    - N: `pos_y`+1
    - E: `pos_x`+1
    - S: `pos_y`−1
    - W: `pos_x`−1
  - Next state is IDLE.
- Compound command (`front`=1 and `rotate`=1): rotate first, then move along the new heading.
- Position arithmetic: modulo 2^COORD_W. Wrap-around is silent, e.g. 127+1 → −128 for COORD_W=8.
- `step_count` increments by 1 per completed MOVE and saturates at 16'hFFFF.
- `motor_fwd` and `motor_turn` are never high in the same cycle.
- One internal duration counter is shared by TURN and MOVE and is reloaded on each state entry.

## Timing
- Reset: synchronous, applied on any edge where `reset`=1. Values after reset:
  - state=IDLE, so `cmd_ready`=1
  - `motor_fwd`=0, `motor_turn`=0
  - `heading`=0 (N)
  - `pos_x`=0, `pos_y`=0
  - `step_count`=0
  - `at_origin`=1
- Accept at edge k:
  - Rotate-only: `motor_turn` is high for cycles k+1 … k+TURN_CYCLES. `heading` updates at edge k+TURN_CYCLES+1. `cmd_ready`=1 from cycle k+TURN_CYCLES+1.
  - Front-only: `motor_fwd` is high for cycles k+1 … k+MOVE_CYCLES. Position and `step_count` update at edge k+MOVE_CYCLES+1. `cmd_ready` returns in the same cycle the new position becomes visible.
  - Compound: `motor_fwd` starts on the cycle immediately after the last `motor_turn` cycle, with no gap. The command takes TURN_CYCLES+MOVE_CYCLES busy cycles in total.
- Back-to-back commands: a command presented on the cycle `cmd_ready` rises is accepted. Turnaround is zero cycles.
- No-op accept: `cmd_ready` stays 1 and nothing changes.
- `at_origin` is derived from the registered coordinates, with no extra latency.
- Reset during TURN or MOVE: abort the command. Motors are 0 and state is IDLE after that edge. The partial move is not committed, so neither heading nor position update.

## Test plan
- Reset, then `cmd_valid`=1, `front`=1, `rotate`=0 (defaults) → `motor_fwd` high for 4 cycles, `motor_turn` never high; then `pos_y`=1, `step_count`=1, `at_origin`=0, `cmd_ready`=1.
- Four rotate-only commands → `motor_turn` high for 2 cycles each; `heading` steps 1, 2, 3, 0; position is unchanged and `at_origin` stays 1.
- Compound command from heading N → 2 `motor_turn` cycles, then 4 `motor_fwd` cycles with no gap; final state `heading`=1, `pos_x`=1, `pos_y`=0.
- Sequence fwd, rot, rot, fwd from reset → returns to the origin with `at_origin`=1, `heading`=2, `step_count`=2. Hold `cmd_valid`=1 throughout and check each command is accepted on the first cycle `cmd_ready` is high. Check that toggling inputs while busy has no effect.
- Two stress cases:
  - 128 forward moves facing N with COORD_W=8 → `pos_y` wraps to −128 (8'h80).
  - A no-op command (both 0) → zero busy cycles, no state change.
- Assert `reset` in the 2nd `motor_fwd` cycle → motors are 0 on the next cycle, position and `step_count` are all 0, `cmd_ready`=1.
